imem_pipe: RTL and testbench
============================

IMEM_PIPE -- requirements
Module: imem_pipe

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 16384, byte capacity; power of two, multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 32, width of fetch and load addresses.
REQ-003 SHALL have ports `clk` (input, 1) as the single clock and `rst_n` (input, 1) as the reset; reset is asynchronous and active-low.
REQ-004 SHALL have the fetch request ports:
- `req_valid` (input, 1): fetch request.
- `req_pc` (input, ADDR_W): fetch byte address.
- `req_ready` (output, 1): request accepted when high with `req_valid`.
REQ-005 SHALL have the fetch response ports:
- `resp_valid` (output, 1): response held.
- `resp_ready` (input, 1): consumer takes the response.
- `instruction` (output, 32): fetched word.
- `resp_pc` (output, ADDR_W): address of the response.
- `resp_fault` (output, 1): misaligned or out-of-range fetch.
- `resp_perr` (output, 1): parity error.
REQ-006 SHALL have the load port:
- `ld_en` (input, 1): byte write.
- `ld_addr` (input, ADDR_W): byte address.
- `ld_data` (input, 8): byte value.
- `ld_perr_inj` (input, 1): store inverted parity.
REQ-007 SHALL have `init_done` (output, 1), high once memory clear completes.

Function
REQ-008 SHALL store bytes big-endian: `instruction` = {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}.
REQ-009 SHALL run FSM CLEAR -> RUN.
- CLEAR writes one zero word per cycle, index 0 to DEPTH_BYTES/4-1.
- RUN is entered the cycle after the last word is written.
- RUN holds until reset.
REQ-010 SHALL hold `init_done`=0 in CLEAR and `init_done`=1 in RUN; CLEAR lasts exactly DEPTH_BYTES/4 cycles.
REQ-011 SHALL drive `req_ready` = RUN & !`ld_en` & (!`resp_valid` | `resp_ready`).
REQ-012 SHALL register an accepted request into the response stage at the next rising edge: one-cycle latency, `resp_valid`=1, `resp_pc`=`req_pc`.
REQ-013 SHALL hold `resp_valid` and all response fields stable while `resp_valid`=1 and `resp_ready`=0.
REQ-014 SHALL clear `resp_valid` on `resp_ready`=1 unless a new request is accepted in the same cycle, in which case the new response replaces the old one with no bubble.
REQ-015 SHALL set `resp_fault`=1 and `instruction`=0 if `req_pc`[1:0]!=0 or `req_pc`>DEPTH_BYTES-4; memory is not read in that case.
REQ-016 SHALL in RUN write `ld_data` to mem[`ld_addr`] at the edge when `ld_en`=1 and `ld_addr`<DEPTH_BYTES; out-of-range loads SHALL be dropped silently.
REQ-017 SHALL ignore `ld_en` during CLEAR.
REQ-018 SHALL give load priority over fetch, because `req_ready` is low whenever `ld_en`=1, so no read/write collision is possible.
REQ-019 SHALL return pre-load data for a response already registered; a later fetch of the same word SHALL return the loaded data.

Reset
REQ-020 SHALL on `rst_n`=0 asynchronously force:
- FSM to CLEAR with clear index 0.
- `init_done`=0 and `resp_valid`=0.
- `instruction`=0, `resp_pc`=0, `resp_fault`=0, `resp_perr`=0.
REQ-021 SHALL on reset asserted mid-CLEAR or mid-RUN discard any in-flight response and restart the clear sweep from index 0 after release.
REQ-022 SHALL NOT depend on array contents being reset asynchronously; the CLEAR sweep alone zeroes memory.

Configuration
REQ-023 SHALL support macro IMEM_PARITY_EN.
- Defined: one even-parity bit per byte, written by CLEAR and by load. Load stores inverted parity if `ld_perr_inj`=1.
- Defined: on a non-faulting fetch, `resp_perr`=1 if any of the 4 bytes mismatches its parity; the data is still returned.
- Undefined: no parity storage; `resp_perr` is tied 0 and `ld_perr_inj` is ignored.

Verification
REQ-024 SHALL cover the clear sweep: DEPTH_BYTES=64, release reset.
- `init_done` rises after exactly 16 cycles.
- A fetch at pc 0 returns 0x00000000.
REQ-025 SHALL cover load then fetch: load bytes 48,08,00,04 to addresses 100..103, then fetch pc 100.
- `instruction`=0x48080004 one cycle later, `resp_pc`=100.
- `resp_fault`=0.
REQ-026 SHALL cover backpressure: fetches of pc 100 then 104 with `resp_ready`=0 for 3 cycles.
- The pc 100 response is held stable and `req_ready`=0.
- After `resp_ready`=1, both responses emerge in order with no loss.
REQ-027 SHALL cover faults, with DEPTH_BYTES=16384:
- Fetch pc 102 -> `resp_fault`=1, `instruction`=0.
- Fetch pc 16384 -> `resp_fault`=1.
- Fetch pc 16380 -> `resp_fault`=0.
REQ-028 SHALL cover a load/fetch collision: `ld_en`=1 with `req_valid`=1 in the same cycle -> `req_ready`=0, the load completes, and the fetch is accepted the next cycle.
REQ-029 SHALL cover parity with IMEM_PARITY_EN defined: load byte 0x24 at addr 200 with `ld_perr_inj`=1, then fetch pc 200 -> `resp_perr`=1, `instruction`[31:24]=0x24; with the macro undefined -> `resp_perr`=0.

Source files
------------

// File: rtl/imem_pipe.sv
// imem_pipe: byte-loadable instruction memory with a one-deep fetch response stage.
// After reset, a CLEAR sweep writes zero to every word, one word per cycle.
// The block then enters RUN, where byte loads and 32-bit big-endian fetches are served.
// Optional macro IMEM_PARITY_EN adds one even-parity bit per byte.
//   - A load can inject a parity error into the byte it writes.
//   - A fetch reports any parity mismatch on resp_perr.
module imem_pipe #(
    parameter int DEPTH_BYTES = 16384,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch request
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    // fetch response
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] resp_pc,
    output logic              resp_fault,
    output logic              resp_perr,
    // byte load port
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ld_perr_inj,
    // status
    output logic              init_done
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;

    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic              resp_fault_q, resp_fault_d;

    // shared memory write port (clear sweep or byte load)
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_lane_en;
    logic [7:0]        wr_byte;
    logic              wr_par;
    logic              ld_hit;

    // fetch side
    logic              accept;
    logic              fetch_fault;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [7:0]        rd_byte [4];
    logic [3:0]        byte_bad;
    logic              run;

    assign run = (state_q == ST_RUN);

    // Clear sweep sequencing: walk every word index once, then park in RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == LAST_IDX) begin
                state_d   = ST_RUN;
                clr_idx_d = '0;
            end
        end
    end

    // FSM and clear index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign init_done = run;

    // A load always wins the cycle, so a fetch never reads while a write lands.
    assign req_ready   = run & ~ld_en & (~resp_valid_q | resp_ready);
    assign accept      = req_valid & req_ready;
    assign fetch_fault = (req_pc[1:0] != 2'b00) || (req_pc > LAST_PC);
    assign rd_en       = accept & ~fetch_fault;
    assign rd_idx      = req_pc[IDX_W+1:2];

    // Write port mux: CLEAR zeroes all four lanes, RUN writes one byte lane on a load.
    always_comb begin
        wr_idx     = clr_idx_q;
        wr_lane_en = 4'b0000;
        wr_byte    = 8'h00;
        wr_par     = 1'b0;
        ld_hit     = run && ld_en && (ld_addr < DEPTH_A);
        if (state_q == ST_CLEAR) begin
            wr_lane_en = 4'b1111;
        end else if (ld_hit) begin
            wr_idx                  = ld_addr[IDX_W+1:2];
            wr_byte                 = ld_data;
            wr_lane_en[ld_addr[1:0]] = 1'b1;
`ifdef IMEM_PARITY_EN
            wr_par                  = (^ld_data) ^ ld_perr_inj;
`endif
        end
    end

`ifndef IMEM_PARITY_EN
    // Parity is compiled out, so the injection input and the parity write bit have no sink.
    logic unused_parity;
    assign unused_parity = ld_perr_inj ^ wr_par;
`endif

    // One byte lane per address offset; lane 0 holds the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:WORDS-1];
            logic [7:0] rd_byte_q;

            // Byte-lane RAM with registered read; the read register only moves on a real fetch.
            always_ff @(posedge clk) begin
                if (wr_lane_en[gi]) begin
                    mem[wr_idx] <= wr_byte;
                end
                if (rd_en) begin
                    rd_byte_q <= mem[rd_idx];
                end
            end

            assign rd_byte[gi] = rd_byte_q;

`ifdef IMEM_PARITY_EN
            logic par_mem [0:WORDS-1];
            logic rd_par_q;

            // Parity bit RAM alongside each byte lane, written and read with it.
            always_ff @(posedge clk) begin
                if (wr_lane_en[gi]) begin
                    par_mem[wr_idx] <= wr_par;
                end
                if (rd_en) begin
                    rd_par_q <= par_mem[rd_idx];
                end
            end

            assign byte_bad[gi] = (^rd_byte_q) ^ rd_par_q;
`else
            assign byte_bad[gi] = 1'b0;
`endif
        end
    endgenerate

    // Response stage: load on accept, otherwise drop when consumed, otherwise hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        resp_fault_d = resp_fault_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_pc_d    = req_pc;
            resp_fault_d = fetch_fault;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Response stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // The RAM read registers are not reset.
    // Data is therefore masked to zero unless a valid non-faulting response is held.
    assign resp_valid  = resp_valid_q;
    assign resp_pc     = resp_pc_q;
    assign resp_fault  = resp_fault_q;
    assign instruction = (resp_valid_q && !resp_fault_q)
                         ? {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]}
                         : 32'h0000_0000;
    assign resp_perr   = resp_valid_q & ~resp_fault_q & (|byte_bad);

endmodule

// File: tb/tb_imem_pipe.sv
// Testbench for imem_pipe.
// One large instance is used for the main features.
// One small 64-byte instance is used for the short clear sweep.
// Expected values come from a byte-array model of memory and parity plus a single-slot response scoreboard.
`timescale 1ns/1ps
module tb_imem_pipe;

    localparam int DEPTH  = 16384;
    localparam int SDEPTH = 64;
`ifdef IMEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_fault, resp_perr;
    logic        ld_en, ld_perr_inj, init_done;
    logic [31:0] req_pc, resp_pc, instruction, ld_addr;
    logic [7:0]  ld_data;

    logic        s_req_valid, s_req_ready, s_resp_valid, s_resp_ready, s_resp_fault, s_resp_perr;
    logic        s_ld_en, s_ld_perr_inj, s_init_done;
    logic [31:0] s_req_pc, s_resp_pc, s_instruction, s_ld_addr;
    logic [7:0]  s_ld_data;

    int total = 0;
    int bad   = 0;

    byte unsigned mem_model [DEPTH];
    bit           par_bad   [DEPTH];

    imem_pipe #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .instruction(instruction),
        .resp_pc(resp_pc), .resp_fault(resp_fault), .resp_perr(resp_perr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_perr_inj(ld_perr_inj),
        .init_done(init_done)
    );

    imem_pipe #(.DEPTH_BYTES(SDEPTH), .ADDR_W(32)) u_small (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_pc(s_req_pc), .req_ready(s_req_ready),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .instruction(s_instruction),
        .resp_pc(s_resp_pc), .resp_fault(s_resp_fault), .resp_perr(s_resp_perr),
        .ld_en(s_ld_en), .ld_addr(s_ld_addr), .ld_data(s_ld_data), .ld_perr_inj(s_ld_perr_inj),
        .init_done(s_init_done)
    );

    // ---------------- reference model ----------------
    function automatic bit m_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc > 32'(DEPTH - 4));
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] pc);
        if (m_fault(pc)) return 32'h0;
        return {mem_model[pc], mem_model[pc+1], mem_model[pc+2], mem_model[pc+3]};
    endfunction

    function automatic bit m_perr(input logic [31:0] pc);
        if (m_fault(pc)) return 1'b0;
        return par_bad[pc] | par_bad[pc+1] | par_bad[pc+2] | par_bad[pc+3];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem_model[i] = 8'h00;
            par_bad[i]   = 1'b0;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_pc = 0; resp_ready = 1; ld_en = 0; ld_addr = 0; ld_data = 0; ld_perr_inj = 0;
    endtask

    task automatic load_byte(input logic [31:0] addr, input logic [7:0] data, input bit inj);
        ld_en = 1; ld_addr = addr; ld_data = data; ld_perr_inj = inj;
        tick();
        ld_en = 0; ld_perr_inj = 0;
        if (addr < DEPTH) begin
            mem_model[addr] = data;
            par_bad[addr]   = PAR_EN && inj;
        end
        $display("load addr=%0d data=%02h inj=%0d", addr, data, inj);
    endtask

    task automatic fetch_one(input logic [31:0] pc, output bit ok, output logic rv,
                             output logic [31:0] ins, output logic [31:0] rpc,
                             output logic flt, output logic per);
        ok = 0;
        req_valid = 1; req_pc = pc; resp_ready = 1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        req_valid = 0;
        rv = resp_valid; ins = instruction; rpc = resp_pc; flt = resp_fault; per = resp_perr;
        $display("fetch pc=%0d valid=%0d instr=%08h fault=%0d perr=%0d", pc, rv, ins, flt, per);
    endtask

    task automatic wait_init(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 6000; n++) begin
            tick();
            if (init_done === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        s_req_valid = 0; s_req_pc = 0; s_resp_ready = 1; s_ld_en = 0; s_ld_addr = 0; s_ld_data = 0; s_ld_perr_inj = 0;
        repeat (3) tick();
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instruction: got %h want 0", instruction); end
        total++; if (resp_pc !== 32'h0) begin bad++; $display("FAIL reset_resp_pc: got %h want 0", resp_pc); end
        total++; if ({resp_fault, resp_perr} !== 2'b00) begin bad++; $display("FAIL reset_fault_perr: got %b want 00", {resp_fault, resp_perr}); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        $display("reset checked");
    endtask

    task automatic test_clear_sweep();
        int big_n = -1;
        int small_n = -1;
        rst_n = 1;
        for (int n = 1; n <= 6000 && big_n < 0; n++) begin
            tick();
            if (small_n < 0 && s_init_done === 1'b1) small_n = n;
            if (init_done === 1'b1) big_n = n;
        end
        total++; if (small_n != SDEPTH/4) begin bad++; $display("FAIL clear_small_cycles: got %0d want %0d", small_n, SDEPTH/4); end
        total++; if (big_n != DEPTH/4) begin bad++; $display("FAIL clear_big_cycles: got %0d want %0d", big_n, DEPTH/4); end
        $display("clear sweep small=%0d big=%0d cycles", small_n, big_n);
        model_clear();
        // small instance: pc 0 reads zero, pc 60 is the last word, pc 64 faults
        s_req_valid = 1; s_req_pc = 0; s_resp_ready = 1;
        #1;
        total++; if (s_req_ready !== 1'b1) begin bad++; $display("FAIL small_req_ready: got %b want 1", s_req_ready); end
        tick();
        total++; if ({s_resp_valid, s_resp_fault, s_instruction} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL small_pc0: got v=%b f=%b i=%h want v=1 f=0 i=00000000", s_resp_valid, s_resp_fault, s_instruction);
        end
        s_req_pc = 60;
        tick();
        total++; if ({s_resp_valid, s_resp_fault, s_resp_pc} !== {2'b10, 32'd60}) begin
            bad++; $display("FAIL small_pc60: got v=%b f=%b pc=%0d want v=1 f=0 pc=60", s_resp_valid, s_resp_fault, s_resp_pc);
        end
        s_req_pc = 64;
        tick();
        total++; if ({s_resp_valid, s_resp_fault} !== 2'b11) begin
            bad++; $display("FAIL small_pc64_fault: got v=%b f=%b want v=1 f=1", s_resp_valid, s_resp_fault);
        end
        s_req_valid = 0;
        tick();
    endtask

    task automatic test_load_fetch();
        bit ok; logic rv, flt, per; logic [31:0] ins, rpc;
        load_byte(100, 8'h48, 0);
        load_byte(101, 8'h08, 0);
        load_byte(102, 8'h00, 0);
        load_byte(103, 8'h04, 0);
        fetch_one(100, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || rv !== 1'b1) begin bad++; $display("FAIL load_fetch_accept: got ok=%0d v=%b want 1", ok, rv); end
        total++; if (ins !== 32'h48080004) begin bad++; $display("FAIL load_fetch_instr: got %h want 48080004", ins); end
        total++; if (rpc !== 32'd100 || flt !== 1'b0) begin bad++; $display("FAIL load_fetch_pc_fault: got pc=%0d f=%b want pc=100 f=0", rpc, flt); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] want100, want104;
        load_byte(104, 8'hDE, 0);
        load_byte(105, 8'hAD, 0);
        load_byte(106, 8'hBE, 0);
        load_byte(107, 8'hEF, 0);
        want100 = m_instr(100);
        want104 = m_instr(104);
        resp_ready = 0; req_valid = 1; req_pc = 100;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready: got %b want 1", req_ready); end
        tick();
        req_pc = 104;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0 (cycle %0d)", req_ready, k); end
            total++; if ({resp_valid, resp_pc, instruction} !== {1'b1, 32'd100, want100}) begin
                bad++; $display("FAIL bp_hold: got v=%b pc=%0d i=%h want v=1 pc=100 i=%h", resp_valid, resp_pc, instruction, want100);
            end
            tick();
        end
        $display("held response pc=%0d instr=%08h", resp_pc, instruction);
        resp_ready = 1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
        tick();
        req_valid = 0;
        total++; if ({resp_valid, resp_pc, instruction} !== {1'b1, 32'd104, want104}) begin
            bad++; $display("FAIL bp_second: got v=%b pc=%0d i=%h want v=1 pc=104 i=%h", resp_valid, resp_pc, instruction, want104);
        end
        $display("second response pc=%0d instr=%08h", resp_pc, instruction);
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", resp_valid); end
    endtask

    task automatic test_faults();
        bit ok; logic rv, flt, per; logic [31:0] ins, rpc;
        fetch_one(102, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || {rv, flt, ins} !== {2'b11, 32'h0}) begin bad++; $display("FAIL fault_102: got v=%b f=%b i=%h want v=1 f=1 i=0", rv, flt, ins); end
        fetch_one(DEPTH, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || {rv, flt} !== 2'b11) begin bad++; $display("FAIL fault_16384: got v=%b f=%b want v=1 f=1", rv, flt); end
        fetch_one(DEPTH - 4, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || {rv, flt, ins} !== {2'b10, m_instr(DEPTH - 4)}) begin bad++; $display("FAIL fault_16380: got v=%b f=%b i=%h want v=1 f=0", rv, flt, ins); end
        fetch_one(32'hFFFF_FFFC, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || {rv, flt} !== 2'b11) begin bad++; $display("FAIL fault_high: got v=%b f=%b want v=1 f=1", rv, flt); end
        tick();
    endtask

    task automatic test_collision();
        ld_en = 1; ld_addr = 300; ld_data = 8'h5A; ld_perr_inj = 0;
        req_valid = 1; req_pc = 300; resp_ready = 1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL coll_ready_low: got %b want 0", req_ready); end
        tick();
        mem_model[300] = 8'h5A;
        par_bad[300]   = 1'b0;
        ld_en = 0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL coll_ready_next: got %b want 1", req_ready); end
        tick();
        req_valid = 0;
        total++; if ({resp_valid, resp_pc, instruction} !== {1'b1, 32'd300, 32'h5A000000}) begin
            bad++; $display("FAIL coll_fetch: got v=%b pc=%0d i=%h want v=1 pc=300 i=5a000000", resp_valid, resp_pc, instruction);
        end
        $display("collision fetch pc=%0d instr=%08h", resp_pc, instruction);
        tick();
    endtask

    task automatic test_parity();
        bit ok; logic rv, flt, per; logic [31:0] ins, rpc;
        load_byte(200, 8'h24, 1);
        fetch_one(200, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || per !== PAR_EN) begin bad++; $display("FAIL parity_perr: got %b want %b", per, PAR_EN); end
        total++; if (ins !== 32'h24000000) begin bad++; $display("FAIL parity_data: got %h want 24000000", ins); end
        fetch_one(204, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || per !== 1'b0) begin bad++; $display("FAIL parity_clean: got %b want 0", per); end
        tick();
    endtask

    task automatic test_random();
        bit          exp_v = 0;
        logic [31:0] exp_i = 0, exp_pc = 0;
        bit          exp_f = 0, exp_p = 0;
        bit          exp_rdy;
        int          r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            total++; if (resp_valid !== exp_v) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, resp_valid, exp_v); end
            if (exp_v) begin
                total++;
                if ({instruction, resp_pc, resp_fault, resp_perr} !== {exp_i, exp_pc, exp_f, exp_p}) begin
                    bad++; $display("FAIL rnd_resp@%0d: got i=%h pc=%0d f=%b p=%b want i=%h pc=%0d f=%b p=%b",
                                    cyc, instruction, resp_pc, resp_fault, resp_perr, exp_i, exp_pc, exp_f, exp_p);
                end
            end
            ld_en       = ($urandom_range(0, 4) == 0);
            ld_addr     = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 63)) : 32'($urandom_range(0, 511));
            ld_data     = 8'($urandom);
            ld_perr_inj = ($urandom_range(0, 3) == 0);
            req_valid   = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            if (r == 0)      req_pc = 32'($urandom_range(0, 511));
            else if (r == 1) req_pc = 32'(DEPTH - 8 + 4 * $urandom_range(0, 3));
            else             req_pc = 32'(4 * $urandom_range(0, 127));
            resp_ready  = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = !ld_en && (!exp_v || resp_ready);
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            if (exp_v && resp_ready) begin
                $display("rnd resp pc=%0d instr=%08h fault=%0d perr=%0d", exp_pc, exp_i, exp_f, exp_p);
                exp_v = 0;
            end
            if (req_valid && exp_rdy) begin
                exp_v  = 1;
                exp_pc = req_pc;
                exp_f  = m_fault(req_pc);
                exp_i  = m_instr(req_pc);
                exp_p  = PAR_EN && m_perr(req_pc);
            end
            if (ld_en && ld_addr < DEPTH) begin
                mem_model[ld_addr] = ld_data;
                par_bad[ld_addr]   = PAR_EN && ld_perr_inj;
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain: got %b want 0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok; logic rv, flt, per; logic [31:0] ins, rpc;
        // reset during CLEAR restarts the sweep from index 0
        rst_n = 0; tick(); rst_n = 1;
        repeat (100) tick();
        rst_n = 0;
        #1;
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL mid_clear_init: got %b want 0", init_done); end
        tick(); rst_n = 1;
        wait_init(n);
        total++; if (n != DEPTH/4) begin bad++; $display("FAIL mid_clear_cycles: got %0d want %0d", n, DEPTH/4); end
        // reset during RUN with a held response discards it and re-zeroes memory
        load_byte(400, 8'h11, 0);
        resp_ready = 0; req_valid = 1; req_pc = 400;
        tick();
        req_valid = 0;
        total++; if ({resp_valid, instruction} !== {1'b1, 32'h11000000}) begin bad++; $display("FAIL mid_run_held: got v=%b i=%h want v=1 i=11000000", resp_valid, instruction); end
        rst_n = 0;
        #1;
        total++; if ({resp_valid, instruction, resp_pc} !== {1'b0, 32'h0, 32'h0}) begin
            bad++; $display("FAIL mid_run_discard: got v=%b i=%h pc=%0d want all 0", resp_valid, instruction, resp_pc);
        end
        tick(); rst_n = 1; resp_ready = 1;
        wait_init(n);
        total++; if (n != DEPTH/4) begin bad++; $display("FAIL mid_run_cycles: got %0d want %0d", n, DEPTH/4); end
        model_clear();
        fetch_one(400, ok, rv, ins, rpc, flt, per);
        total++; if (!ok || {rv, ins, per} !== {1'b1, 32'h0, 1'b0}) begin bad++; $display("FAIL mid_run_rezero: got v=%b i=%h p=%b want v=1 i=0 p=0", rv, ins, per); end
        tick();
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_load_fetch();
        test_back_to_back();
        test_faults();
        test_collision();
        test_parity();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
